// File: rtl/regbank_irq_sequencer_pkg.sv
// Shared types and constants for the interrupt bank-switch sequencer.
// Holds the state encoding, the bank numbers and the PC register index.
package regbank_irq_sequencer_pkg;

    typedef enum logic [2:0] {
        USER,
        ENTER_WAIT,
        LOAD,
        ENTER_SETTLE,
        HANDLER,
        EXIT_WAIT,
        EXIT_SETTLE
    } seq_state_t;

    localparam logic       USER_BANK  = 1'b0;
    localparam logic       IRQ_BANK   = 1'b1;
    localparam logic [2:0] PC_REG_NUM = 3'd6;
    localparam int         PC_WIDTH   = 16;

endpackage

// File: rtl/regbank_irq_sequencer_if.sv
// Bundle between the decoder/control unit, the register file and the sequencer.
// The slave modport is the sequencer's view; master is the core/register-file side.
interface regbank_irq_sequencer_if;
    import regbank_irq_sequencer_pkg::*;

    logic                irq_req;
    logic                irq_enable;
    logic [PC_WIDTH-1:0] irq_vector;
    logic                core_idle;
    logic                reti;
    logic                stall;
    logic                active_bank;
    logic [PC_WIDTH-1:0] pc_register_in;
    logic                pc_write_en;
    logic                irq_ack;
    logic                in_handler;
    logic                spurious_reti;

    modport slave (
        input  irq_req, irq_enable, irq_vector, core_idle, reti,
        output stall, active_bank, pc_register_in, pc_write_en,
               irq_ack, in_handler, spurious_reti
    );

    modport master (
        output irq_req, irq_enable, irq_vector, core_idle, reti,
        input  stall, active_bank, pc_register_in, pc_write_en,
               irq_ack, in_handler, spurious_reti
    );

endinterface

// File: rtl/regbank_irq_sequencer.sv
// Switches the register file to the interrupt bank on entry, loads the handler
// vector into that bank's PC, and restores the user bank on return.
module regbank_irq_sequencer
    import regbank_irq_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    regbank_irq_sequencer_if.slave bus
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_t          state;
    logic [PC_WIDTH-1:0] vec_q;
    logic [3:0]          settle_cnt;
    logic                stall_q;
    logic                active_bank_q;
    logic [PC_WIDTH-1:0] pc_register_q;
    logic                pc_write_en_q;
    logic                irq_ack_q;
    logic                in_handler_q;
    logic                spurious_q;

    // LOAD registers the write strobe, so the write is visible during the first
    // ENTER_SETTLE cycle; that cycle only drops the strobe before counting starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= USER;
            vec_q         <= '0;
            settle_cnt    <= '0;
            stall_q       <= 1'b0;
            active_bank_q <= USER_BANK;
            pc_register_q <= '0;
            pc_write_en_q <= 1'b0;
            irq_ack_q     <= 1'b0;
            in_handler_q  <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            irq_ack_q  <= 1'b0;
            spurious_q <= 1'b0;
            case (state)
                USER: begin
                    if (bus.irq_req && bus.irq_enable) begin
                        vec_q   <= bus.irq_vector;
                        stall_q <= 1'b1;
                        state   <= ENTER_WAIT;
                    end
                    if (bus.reti) begin
                        spurious_q <= 1'b1;
                    end
                end
                ENTER_WAIT: begin
                    if (bus.core_idle) begin
                        active_bank_q <= IRQ_BANK;
                        irq_ack_q     <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    pc_write_en_q <= 1'b1;
                    pc_register_q <= vec_q;
                    settle_cnt    <= SETTLE_LOAD;
                    state         <= ENTER_SETTLE;
                end
                ENTER_SETTLE: begin
                    if (pc_write_en_q) begin
                        pc_write_en_q <= 1'b0;
                    end else if (settle_cnt == 4'd0) begin
                        stall_q      <= 1'b0;
                        in_handler_q <= 1'b1;
                        state        <= HANDLER;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                HANDLER: begin
                    if (bus.reti) begin
                        stall_q <= 1'b1;
                        state   <= EXIT_WAIT;
                    end
                end
                EXIT_WAIT: begin
                    if (bus.core_idle) begin
                        active_bank_q <= USER_BANK;
                        in_handler_q  <= 1'b0;
                        settle_cnt    <= SETTLE_LOAD;
                        state         <= EXIT_SETTLE;
                    end
                end
                EXIT_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        stall_q <= 1'b0;
                        state   <= USER;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= USER;
                end
            endcase
        end
    end

    assign bus.stall          = stall_q;
    assign bus.active_bank    = active_bank_q;
    assign bus.pc_register_in = pc_register_q;
    assign bus.pc_write_en    = pc_write_en_q;
    assign bus.irq_ack        = irq_ack_q;
    assign bus.in_handler     = in_handler_q;
    assign bus.spurious_reti  = spurious_q;

endmodule

// File: tb/tb_regbank_irq_sequencer.sv
// Randomized interrupt entry/exit rounds; expected events are timestamped from the
// latency rules and matched by a monitor that also keeps a register-file PC model.
module tb_regbank_irq_sequencer;
    import regbank_irq_sequencer_pkg::*;

    localparam int SETTLE = 3;

    localparam int EV_STALL_UP = 0;
    localparam int EV_STALL_DN = 1;
    localparam int EV_BANK_UP  = 2;
    localparam int EV_BANK_DN  = 3;
    localparam int EV_ACK      = 4;
    localparam int EV_PCW      = 5;
    localparam int EV_IH_UP    = 6;
    localparam int EV_IH_DN    = 7;
    localparam int EV_SPUR     = 8;

    typedef struct {
        int          cyc;
        int          kind;
        logic [16:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic mon_en = 1'b0;
    logic prev_stall = 1'b0, prev_bank = 1'b0, prev_ih = 1'b0;
    logic [15:0] rf [0:1][0:7];
    logic [15:0] last_vec = 16'h0000;
    exp_t exp_q[$];

    regbank_irq_sequencer_if bus();

    regbank_irq_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ename(input int k);
        case (k)
            EV_STALL_UP: return "stall_rise";
            EV_STALL_DN: return "stall_fall";
            EV_BANK_UP:  return "bank_to_irq";
            EV_BANK_DN:  return "bank_to_user";
            EV_ACK:      return "irq_ack";
            EV_PCW:      return "pc_write";
            EV_IH_UP:    return "in_handler_rise";
            EV_IH_DN:    return "in_handler_fall";
            default:     return "spurious_reti";
        endcase
    endfunction

    // Queue stays sorted by (cycle, kind) so same-cycle events match monitor order.
    function automatic void push_exp(input int k, input int c, input logic [16:0] d);
        int i = 0;
        exp_t e;
        e.cyc = c; e.kind = k; e.data = d;
        while (i < exp_q.size() && (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= k)))
            i++;
        exp_q.insert(i, e);
    endfunction

    function automatic void observe(input int k, input logic [16:0] d);
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL %s: got event at cycle %0d data %h, required no event", ename(k), cyc, d);
        end else if (exp_q[0].cyc != cyc || exp_q[0].kind != k || exp_q[0].data !== d) begin
            miscompares++;
            $display("[TB] FAIL %s: got event at cycle %0d data %h, required %s at cycle %0d data %h",
                     ename(k), cyc, d, ename(exp_q[0].kind), exp_q[0].cyc, exp_q[0].data);
            if (exp_q[0].cyc == cyc) void'(exp_q.pop_front());
        end else begin
            void'(exp_q.pop_front());
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL %s: got nothing by cycle %0d, required event at cycle %0d",
                         ename(exp_q[0].kind), cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.stall && !prev_stall)             observe(EV_STALL_UP, 17'd0);
            if (!bus.stall && prev_stall)             observe(EV_STALL_DN, 17'd0);
            if (bus.active_bank && !prev_bank)        observe(EV_BANK_UP, 17'd0);
            if (!bus.active_bank && prev_bank)        observe(EV_BANK_DN, 17'd0);
            if (bus.irq_ack)                          observe(EV_ACK, 17'd0);
            if (bus.pc_write_en) begin
                observe(EV_PCW, {bus.active_bank, bus.pc_register_in});
                rf[bus.active_bank][PC_REG_NUM] = bus.pc_register_in;
            end
            if (bus.in_handler && !prev_ih)           observe(EV_IH_UP, 17'd0);
            if (!bus.in_handler && prev_ih)           observe(EV_IH_DN, 17'd0);
            if (bus.spurious_reti)                    observe(EV_SPUR, 17'd0);
        end
        prev_stall = bus.stall;
        prev_bank  = bus.active_bank;
        prev_ih    = bus.in_handler;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [16:0] actual, input logic [16:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    // USER-state filler: requests with enable low must be ignored, reti pulses are spurious.
    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            bus.irq_enable = 1'b0;
            bus.irq_req    = 1'($urandom_range(0, 1));
            bus.core_idle  = 1'($urandom_range(0, 1));
            bus.reti       = ($urandom_range(0, 3) == 0);
            if (bus.reti) push_exp(EV_SPUR, cyc + 1, 17'd0);
            step();
        end
        bus.reti    = 1'b0;
        bus.irq_req = 1'b0;
    endtask

    // mode 0: normal round; 1: reti collides with a held irq_req (next round chains);
    // 2: reset lands on the LOAD edge.
    task automatic apply_stimulus(input logic [15:0] v, input int din, input int dout,
                                  input int hlen, input int mode);
        int n, a, h, r, b;
        n = cyc + 1;
        bus.irq_req = 1'b1; bus.irq_enable = 1'b1; bus.irq_vector = v;
        bus.core_idle = (din == 0); bus.reti = 1'b0;
        a = n + 1 + din;
        push_exp(EV_STALL_UP, n, 17'd0);
        push_exp(EV_BANK_UP, a, 17'd0);
        push_exp(EV_ACK, a, 17'd0);
        step();
        while (cyc < a) begin
            bus.core_idle  = (cyc + 1 == a);
            bus.irq_req    = 1'($urandom_range(0, 1));
            bus.irq_enable = 1'($urandom_range(0, 1));
            bus.irq_vector = 16'($urandom);
            bus.reti       = 1'($urandom_range(0, 1));
            step();
        end
        bus.reti = 1'b0;
        if (mode == 2) begin
            rst = 1'b1; bus.irq_req = 1'b0;
            push_exp(EV_STALL_DN, a + 1, 17'd0);
            push_exp(EV_BANK_DN, a + 1, 17'd0);
            step();
            rst = 1'b0;
        end else begin
            h = a + 2 + SETTLE;
            r = h + hlen + 1;
            push_exp(EV_PCW, a + 1, {IRQ_BANK, v});
            push_exp(EV_STALL_DN, h, 17'd0);
            push_exp(EV_IH_UP, h, 17'd0);
            while (cyc < r - 1) begin
                bus.core_idle  = 1'($urandom_range(0, 1));
                bus.irq_req    = 1'($urandom_range(0, 1));
                bus.irq_enable = 1'($urandom_range(0, 1));
                step();
            end
            bus.reti = 1'b1;
            bus.irq_req = (mode == 1); bus.irq_enable = (mode == 1);
            b = r + 1 + dout;
            push_exp(EV_STALL_UP, r, 17'd0);
            push_exp(EV_BANK_DN, b, 17'd0);
            push_exp(EV_IH_DN, b, 17'd0);
            push_exp(EV_STALL_DN, b + SETTLE, 17'd0);
            step();
            bus.reti = 1'b0;
            while (cyc < b) begin
                bus.core_idle = (cyc + 1 == b);
                step();
            end
            while (cyc < b + SETTLE) begin
                bus.core_idle = 1'($urandom_range(0, 1));
                step();
            end
            last_vec = v;
        end
        check_output("rf_bank1_pc", {1'b0, rf[IRQ_BANK][PC_REG_NUM]}, {1'b0, last_vec});
        check_output("rf_bank0_pc", {1'b0, rf[USER_BANK][PC_REG_NUM]}, 17'h01234);
    endtask

    initial begin
        int mode;
        for (int bk = 0; bk < 2; bk++)
            for (int rg = 0; rg < 8; rg++)
                rf[bk][rg] = 16'h0000;
        rf[USER_BANK][PC_REG_NUM] = 16'h1234;
        rst = 1'b1;
        bus.irq_req = 1'b0; bus.irq_enable = 1'b0; bus.irq_vector = 16'h0000;
        bus.core_idle = 1'b0; bus.reti = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_output("reset_stall",         {16'd0, bus.stall},         17'd0);
        check_output("reset_active_bank",   {16'd0, bus.active_bank},   17'd0);
        check_output("reset_pc_register",   {1'b0, bus.pc_register_in}, 17'd0);
        check_output("reset_pc_write_en",   {16'd0, bus.pc_write_en},   17'd0);
        check_output("reset_irq_ack",       {16'd0, bus.irq_ack},       17'd0);
        check_output("reset_in_handler",    {16'd0, bus.in_handler},    17'd0);
        check_output("reset_spurious_reti", {16'd0, bus.spurious_reti}, 17'd0);
        mon_en = 1'b1;

        bus.reti = 1'b1;
        push_exp(EV_SPUR, cyc + 1, 17'd0);
        step();
        bus.reti = 1'b0;
        repeat (2) step();

        apply_stimulus(16'h0040, 0, 0, 2, 0);
        idle_cycles(3);
        apply_stimulus(16'h0040, 5, 1, 1, 0);
        idle_cycles(2);
        apply_stimulus(16'h1111, 1, 0, 3, 1);
        apply_stimulus(16'h2222, 0, 2, 0, 0);
        idle_cycles(2);
        apply_stimulus(16'h3333, 2, 0, 0, 2);
        idle_cycles(3);

        for (int i = 0; i < 24; i++) begin
            mode = (i == 23) ? 0 : int'($urandom_range(0, 3));
            if (mode == 3) mode = 0;
            apply_stimulus(16'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 5)), mode);
            if (mode != 1) idle_cycles(int'($urandom_range(0, 4)));
        end

        idle_cycles(4);
        repeat (2) step();
        while (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got nothing by end of run, required event at cycle %0d",
                     ename(exp_q[0].kind), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
